// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and widths for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_IACC = 2'd1,
    MA_DACC = 2'd2,
    MA_DONE = 2'd3
  } ma_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } ma_op_e;

  localparam int TIMER_W  = 16;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Loadable up-counter with clear/enable; tc flags the last cycle before TIMEOUT elapses.
module arb_timeout_counter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // tc is high during the TIMEOUT-th enabled cycle, so the abort lands exactly then
  assign tc = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and load/store; data wins
// unless a waiting fetch has already seen MAX_DSTREAK data grants in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_req,
  input  logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_data_out,
  output logic          imem_ready,
  input  logic          dmem_re,
  input  logic          dmem_wr,
  input  logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_data_in,
  output logic [DW-1:0] dmem_data_out,
  output logic          dmem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          omem_re,
  output logic          omem_wr,
  input  logic          mem_ready,
  output logic          bus_err
);

  ma_state_e           state_reg;
  ma_op_e              op_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [AW-1:0]       addr_reg;
  logic [DW-1:0]       wdata_reg;
  logic [DW-1:0]       idata_reg;
  logic [DW-1:0]       ddata_reg;
  logic                re_reg;
  logic                wr_reg;
  logic                iready_reg;
  logic                dready_reg;
  logic                err_reg;

  logic data_grant;
  logic fetch_grant;
  logic in_acc;
  logic timer_tc;

  assign data_grant  = (state_reg == MA_IDLE) && (dmem_re || dmem_wr) &&
                       !(imem_req && (streak_reg == STREAK_W'(MAX_DSTREAK)));
  assign fetch_grant = (state_reg == MA_IDLE) && !data_grant && imem_req;
  assign in_acc      = (state_reg == MA_IACC) || (state_reg == MA_DACC);

  arb_timeout_counter #(
    .W       (TIMER_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_reg == MA_DONE),
    .load     (data_grant || fetch_grant),
    .load_val ('0),
    .en       (in_acc),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= MA_IDLE;
      op_reg     <= OP_RD;
      streak_reg <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      idata_reg  <= '0;
      ddata_reg  <= '0;
      re_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      iready_reg <= 1'b0;
      dready_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        MA_IDLE: begin
          if (data_grant) begin
            // A simultaneous re+wr is a write
            state_reg  <= MA_DACC;
            addr_reg   <= dmem_addr;
            wdata_reg  <= dmem_data_in;
            op_reg     <= dmem_wr ? OP_WR : OP_RD;
            re_reg     <= !dmem_wr;
            wr_reg     <= dmem_wr;
            streak_reg <= imem_req ? streak_reg + 1'b1 : '0;
          end else if (fetch_grant) begin
            state_reg  <= MA_IACC;
            addr_reg   <= imem_addr;
            op_reg     <= OP_RD;
            re_reg     <= 1'b1;
            streak_reg <= '0;
          end
        end
        MA_IACC, MA_DACC: begin
          if (mem_ready || timer_tc) begin
            state_reg  <= MA_DONE;
            re_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            iready_reg <= (state_reg == MA_IACC);
            dready_reg <= (state_reg == MA_DACC);
            err_reg    <= !mem_ready;
            if (state_reg == MA_IACC) begin
              idata_reg <= mem_ready ? mem_data_out : '0;
            end else if (op_reg == OP_RD) begin
              ddata_reg <= mem_ready ? mem_data_out : '0;
            end
          end
        end
        MA_DONE: begin
          state_reg  <= MA_IDLE;
          iready_reg <= 1'b0;
          dready_reg <= 1'b0;
          err_reg    <= 1'b0;
        end
        default: state_reg <= MA_IDLE;
      endcase
    end
  end

  assign imem_data_out = idata_reg;
  assign imem_ready    = iready_reg;
  assign dmem_data_out = ddata_reg;
  assign dmem_ready    = dready_reg;
  assign mem_addr      = addr_reg;
  assign mem_data_in   = wdata_reg;
  assign omem_re       = re_reg;
  assign omem_wr       = wr_reg;
  assign bus_err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: a memory responder plus a grant-order/data reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data_out;
  logic          imem_ready;
  logic          dmem_re;
  logic          dmem_wr;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_data_in;
  logic [DW-1:0] dmem_data_out;
  logic          dmem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          omem_re;
  logic          omem_wr;
  logic          mem_ready;
  logic          bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .MAX_DSTREAK (MAXD), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_data_out (imem_data_out), .imem_ready (imem_ready),
    .dmem_re (dmem_re), .dmem_wr (dmem_wr), .dmem_addr (dmem_addr),
    .dmem_data_in (dmem_data_in), .dmem_data_out (dmem_data_out),
    .dmem_ready (dmem_ready),
    .mem_addr (mem_addr), .mem_data_in (mem_data_in),
    .mem_data_out (mem_data_out), .omem_re (omem_re), .omem_wr (omem_wr),
    .mem_ready (mem_ready), .bus_err (bus_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        wr;
  } req_t;

  typedef struct {
    logic [1:0]  strobes;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    int          len;
    bit          stable;
  } bus_rec_t;

  typedef struct {
    bit          is_fetch;
    logic [31:0] data;
    logic        err;
  } cpl_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          model_streak = 0;
  logic [31:0] last_dread   = '0;
  int          force_delay  = 0;
  bit          noise_en     = 1'b0;
  logic [31:0] mem_model [logic [31:0]];
  bus_rec_t    bus_q[$];
  bus_rec_t    resp_cur;
  int          resp_cnt;

  function automatic logic [31:0] read_mem(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  // External memory: answers after a per-transaction delay, logs each strobe window
  initial begin
    int pick;
    resp_cnt     = 0;
    mem_ready    = 1'b0;
    mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        resp_cnt  = 0;
        mem_ready = 1'b0;
      end else if (omem_re || omem_wr) begin
        resp_cnt++;
        if (resp_cnt == 1) begin
          resp_cur.strobes = {omem_re, omem_wr};
          resp_cur.addr    = mem_addr;
          resp_cur.wdata   = mem_data_in;
          resp_cur.rdata   = read_mem(mem_addr);
          resp_cur.stable  = 1'b1;
          if (force_delay >= 0) begin
            resp_cur.dly = force_delay;
          end else begin
            pick = int'($urandom_range(0, 9));
            resp_cur.dly = (pick == 0) ? 50 : (pick == 1) ? TMO - 1 : int'($urandom_range(0, 3));
          end
        end else if ({omem_re, omem_wr} !== resp_cur.strobes || mem_addr !== resp_cur.addr ||
                     mem_data_in !== resp_cur.wdata) begin
          resp_cur.stable = 1'b0;
        end
        if (resp_cnt > resp_cur.dly) begin
          mem_ready    = 1'b1;
          mem_data_out = resp_cur.rdata;
          if (resp_cur.strobes == 2'b01) mem_model[resp_cur.addr] = resp_cur.wdata;
        end else begin
          mem_ready    = 1'b0;
          mem_data_out = $urandom;
        end
      end else begin
        if (resp_cnt > 0) begin
          resp_cur.len = resp_cnt;
          bus_q.push_back(resp_cur);
        end
        resp_cnt     = 0;
        mem_ready    = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_data_out = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1);
  end

  task automatic present(input bit fv, input req_t f, input bit dv, input req_t d);
    imem_req     = fv;
    imem_addr    = fv ? f.addr : '0;
    dmem_re      = dv & d.re;
    dmem_wr      = dv & d.wr;
    dmem_addr    = dv ? d.addr : '0;
    dmem_data_in = dv ? d.wdata : '0;
  endtask

  // wr_mode: 0 reads, 1 writes, 2 random (including re+wr together)
  task automatic run_round(input int nf, input int nd, input int wr_mode,
                           input logic [31:0] d0_addr, output int obs_first_fetch);
    req_t     fq[$], dq[$], exp_req[$];
    bit       exp_kind[$];
    cpl_t     obs[$];
    cpl_t     c;
    bus_rec_t b;
    req_t     r;
    int       s, fi, di, budget, k;
    bit       to;
    logic [1:0]  es;
    logic [31:0] ed;
    r = '0;
    for (int i = 0; i < nf; i++) begin
      r.addr = 32'($urandom_range(0, 15)) << 2; r.wdata = $urandom; r.re = 1'b1; r.wr = 1'b0;
      fq.push_back(r);
    end
    for (int i = 0; i < nd; i++) begin
      r.addr  = (i == 0 && d0_addr != 0) ? d0_addr : 32'($urandom_range(0, 15)) << 2;
      r.wdata = $urandom;
      k = (wr_mode == 2) ? int'($urandom_range(0, 2)) : wr_mode;
      r.re = (k != 1); r.wr = (k != 0);
      dq.push_back(r);
    end
    // Reference order: data first unless a waiting fetch has already yielded MAXD times
    s = model_streak; fi = 0; di = 0;
    while (fi < nf || di < nd) begin
      if (di < nd && !(fi < nf && s == MAXD)) begin
        exp_kind.push_back(1'b0); exp_req.push_back(dq[di]); s = (fi < nf) ? s + 1 : 0; di++;
      end else begin
        exp_kind.push_back(1'b1); exp_req.push_back(fq[fi]); s = 0; fi++;
      end
    end
    model_streak = s;

    bus_q.delete();
    fi = 0; di = 0; r = '0;
    budget = (nf + nd) * (TMO + 4) + 10;
    @(negedge clk);
    present(fi < nf, (fi < nf) ? fq[fi] : r, di < nd, (di < nd) ? dq[di] : r);
    while ((fi < nf || di < nd) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (imem_ready === 1'b1) begin
        c.is_fetch = 1'b1; c.data = imem_data_out; c.err = bus_err; obs.push_back(c); fi++;
      end
      if (dmem_ready === 1'b1) begin
        c.is_fetch = 1'b0; c.data = dmem_data_out; c.err = bus_err; obs.push_back(c); di++;
      end
      present(fi < nf, (fi < nf) ? fq[fi] : r, di < nd, (di < nd) ? dq[di] : r);
    end
    present(1'b0, r, 1'b0, r);
    @(negedge clk);
    if (budget == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL round_budget: got %0d of %0d completions, required all", obs.size(), nf + nd);
    end

    obs_first_fetch = -1;
    for (int i = 0; i < obs.size(); i++)
      if (obs[i].is_fetch && obs_first_fetch < 0) obs_first_fetch = i;

    tests_run++;
    if (obs.size() != exp_kind.size()) begin
      tests_failed++;
      $display("FAIL cpl_count: got %0d required %0d", obs.size(), exp_kind.size());
    end
    for (int i = 0; i < obs.size() && i < exp_kind.size(); i++) begin
      $display("[TB] cpl %0d %s data=%h err=%b", i, obs[i].is_fetch ? "fetch" : "data ",
               obs[i].data, obs[i].err);
      tests_run++;
      if (obs[i].is_fetch !== exp_kind[i]) begin
        tests_failed++;
        $display("FAIL grant_order[%0d]: got fetch=%0b required fetch=%0b", i, obs[i].is_fetch, exp_kind[i]);
        continue;
      end
      tests_run++;
      if (i >= bus_q.size()) begin
        tests_failed++;
        $display("FAIL bus_missing[%0d]: got %0d bus windows required more", i, bus_q.size());
        continue;
      end
      b  = bus_q[i];
      to = (b.dly >= TMO);
      es = exp_req[i].wr ? 2'b01 : 2'b10;
      if (b.strobes !== es || b.addr !== exp_req[i].addr || !b.stable ||
          (exp_req[i].wr && b.wdata !== exp_req[i].wdata)) begin
        tests_failed++;
        $display("FAIL bus_xfer[%0d]: got strobes=%b addr=%h wdata=%h stable=%0b required strobes=%b addr=%h wdata=%h",
                 i, b.strobes, b.addr, b.wdata, b.stable, es, exp_req[i].addr, exp_req[i].wdata);
      end
      tests_run++;
      if (b.len != (to ? TMO : b.dly + 1)) begin
        tests_failed++;
        $display("FAIL strobe_len[%0d]: got %0d required %0d", i, b.len, to ? TMO : b.dly + 1);
      end
      tests_run++;
      if (obs[i].err !== to) begin
        tests_failed++;
        $display("FAIL bus_err[%0d]: got %b required %b", i, obs[i].err, to);
      end
      if (!exp_kind[i] && exp_req[i].wr) begin
        ed = last_dread;
      end else begin
        ed = to ? 32'h0 : b.rdata;
        if (!exp_kind[i]) last_dread = ed;
      end
      tests_run++;
      if (obs[i].data !== ed) begin
        tests_failed++;
        $display("FAIL rdata[%0d]: got %h required %h", i, obs[i].data, ed);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h10; dmem_re = 1'b0; dmem_wr = 1'b1;
    dmem_addr = 32'h20; dmem_data_in = 32'h1234_5678;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({omem_re, omem_wr} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_strobes: got %b required 00", {omem_re, omem_wr});
    end
    tests_run++;
    if ({imem_ready, dmem_ready, bus_err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ready: got %b required 000", {imem_ready, dmem_ready, bus_err});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_data_in !== '0) begin
      tests_failed++; $display("FAIL reset_bus: got addr=%h wdata=%h required 0", mem_addr, mem_data_in);
    end
    tests_run++;
    if (imem_data_out !== '0 || dmem_data_out !== '0) begin
      tests_failed++; $display("FAIL reset_data: got i=%h d=%h required 0", imem_data_out, dmem_data_out);
    end
    imem_req = 1'b0; dmem_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_streak = 0; last_dread = '0;
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    force_delay = 0; noise_en = 1'b0;
    mem_model[32'h100] = 32'h0050_0093;
    imem_req = 1'b1; imem_addr = 32'h100;
    @(negedge clk);
    tests_run++;
    if (omem_re !== 1'b1 || omem_wr !== 1'b0 || mem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL fetch_strobe: got re=%b wr=%b addr=%h required re=1 wr=0 addr=00000100", omem_re, omem_wr, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (imem_ready !== 1'b1 || omem_re !== 1'b0 || dmem_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_ready: got iready=%b re=%b dready=%b required 1 0 0", imem_ready, omem_re, dmem_ready);
    end
    tests_run++;
    if (imem_data_out !== 32'h0050_0093) begin
      tests_failed++; $display("FAIL fetch_data: got %h required 00500093", imem_data_out);
    end
    $display("[TB] fetch addr=00000100 data=%h", imem_data_out);
    imem_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_ready !== 1'b0) begin
      tests_failed++; $display("FAIL fetch_pulse: got imem_ready=%b required 0", imem_ready);
    end
    model_streak = 0;
  endtask

  task automatic test_simultaneous();
    int ff;
    force_delay = 0;
    run_round(1, 1, 0, 32'h2000, ff);
  endtask

  task automatic test_write();
    int   cyc = 0;
    bit   seen = 1'b0;
    req_t r, d;
    force_delay = 5; noise_en = 1'b0; r = '0;
    d.addr = 32'h40; d.wdata = 32'hDEAD_BEEF; d.re = 1'b0; d.wr = 1'b1;
    bus_q.delete();
    present(1'b0, r, 1'b1, d);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (omem_wr === 1'b1 && omem_re === 1'b0) cyc++;
      if (dmem_ready === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || bus_err !== 1'b0 || dmem_data_out !== last_dread) begin
      tests_failed++;
      $display("FAIL write_done: got ready=%b err=%b dout=%h required 1 0 %h", seen, bus_err, dmem_data_out, last_dread);
    end
    tests_run++;
    if (cyc != 6) begin
      tests_failed++; $display("FAIL write_strobe_len: got %0d required 6", cyc);
    end
    present(1'b0, r, 1'b0, r);
    @(negedge clk);
    tests_run++;
    if (bus_q.size() != 1 || !bus_q[0].stable || bus_q[0].addr !== 32'h40 || bus_q[0].wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_bus: got windows=%0d required one stable write of deadbeef to 00000040", bus_q.size());
    end
    $display("[TB] write addr=00000040 data=deadbeef strobe_cycles=%0d", cyc);
    model_streak = 0;
  endtask

  task automatic test_timeout();
    int   cyc = 0;
    bit   seen = 1'b0;
    req_t r, d;
    force_delay = 100; r = '0;
    d.addr = 32'h80; d.wdata = '0; d.re = 1'b1; d.wr = 1'b0;
    present(1'b0, r, 1'b1, d);
    for (int i = 0; i < TMO + 10 && !seen; i++) begin
      @(negedge clk);
      if (omem_re === 1'b1) cyc++;
      if (dmem_ready === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen || bus_err !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_err: got ready=%b err=%b required 1 1", seen, bus_err);
    end
    tests_run++;
    if (cyc != TMO) begin
      tests_failed++; $display("FAIL timeout_len: got %0d required %0d", cyc, TMO);
    end
    tests_run++;
    if (dmem_data_out !== 32'h0) begin
      tests_failed++; $display("FAIL timeout_data: got %h required 0", dmem_data_out);
    end
    $display("[TB] timeout read addr=00000080 strobe_cycles=%0d err=%b", cyc, bus_err);
    present(1'b0, r, 1'b0, r);
    @(negedge clk);
    tests_run++;
    if (bus_err !== 1'b0 || dmem_ready !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_clear: got err=%b ready=%b required 0 0", bus_err, dmem_ready);
    end
    last_dread = '0; model_streak = 0; force_delay = 0;
  endtask

  task automatic test_starvation();
    int ff;
    force_delay = 0;
    run_round(2, 10, 1, 32'h0, ff);
    tests_run++;
    if (ff != MAXD) begin
      tests_failed++; $display("FAIL starvation_first_fetch: got index %0d required %0d", ff, MAXD);
    end
  endtask

  task automatic test_async_reset();
    bit bad = 1'b0;
    bit up  = 1'b0;
    force_delay = 100; noise_en = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h104;
    for (int i = 0; i < 5 && !up; i++) begin
      @(negedge clk);
      if (omem_re === 1'b1) up = 1'b1;
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (!up || omem_re !== 1'b0 || imem_ready !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset: got started=%b re=%b iready=%b required 1 0 0", up, omem_re, imem_ready);
    end
    imem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_ready !== 1'b0 || omem_re !== 1'b0 || omem_wr !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad || mem_addr !== '0) begin
      tests_failed++; $display("FAIL post_reset_idle: got activity=%b addr=%h required 0 0", bad, mem_addr);
    end
    $display("[TB] fetch addr=00000104 dropped by reset");
    bus_q.delete();
    model_streak = 0; last_dread = '0;
  endtask

  task automatic test_random();
    int nf, nd, ff;
    force_delay = -1; noise_en = 1'b1;
    for (int rnd = 0; rnd < 40; rnd++) begin
      nf = int'($urandom_range(0, 2));
      nd = int'($urandom_range(0, 6));
      if (nf == 0 && nd == 0) nd = 1;
      run_round(nf, nd, 2, 32'h0, ff);
    end
  endtask

  initial begin
    rst = 1'b0;
    imem_req = 1'b0; imem_addr = '0;
    dmem_re = 1'b0; dmem_wr = 1'b0; dmem_addr = '0; dmem_data_in = '0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_write();
    test_timeout();
    test_starvation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
